// File: rtl/down_timer_8bit.sv
// rtl/down_timer_8bit.sv - 8-bit loadable prescaled down-counter/timer with one-shot or auto-reload
// Drives two active-low 7-segment digits from the live count.
module down_timer_8bit #(
   parameter int         PRESCALE    = 1,
   parameter logic [7:0] RESET_VALUE = 8'h00
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       start,
   input  logic       stop,
   input  logic       auto_reload,
   output logic [7:0] count,
   output logic       busy,
   output logic       expired,
   output logic       tc,
   output logic [6:0] hex_lo,
   output logic [6:0] hex_hi
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // PRESCALE = 256 maps to a terminal prescaler value of 8'hFF.
   localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

   state_e     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] reload_q, reload_d;
   logic [7:0] psc_q, psc_d;
   logic       tc_q, tc_d;

   logic tick;
   logic terminal;

   assign tick     = (psc_q == PS_MAX);
   assign terminal = (count_q <= 8'd1);

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q  <= S_IDLE;
         count_q  <= RESET_VALUE;
         reload_q <= RESET_VALUE;
         psc_q    <= 8'd0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         psc_q    <= psc_d;
         tc_q     <= tc_d;
      end
   end

   // Priority each cycle: load, then stop, then start.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (!stop && start && count_q != 8'd0) state_d = S_RUN;
            S_RUN: begin
               if (stop)                                state_d = S_IDLE;
               else if (tick && terminal && !auto_reload) state_d = S_DONE;
            end
            S_DONE: if (!stop && start && reload_q != 8'd0) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Pausing holds the prescaler, so resuming continues mid-interval.
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      psc_d    = psc_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         psc_d    = 8'd0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (!stop) begin
                  psc_d = tick ? 8'd0 : psc_q + 8'd1;
                  if (tick) begin
                     if (!terminal) begin
                        count_d = count_q - 8'd1;
                     end else begin
                        tc_d    = 1'b1;
                        count_d = auto_reload ? reload_q : 8'd0;
                     end
                  end
               end
            end
            S_DONE: begin
               if (!stop && start && reload_q != 8'd0) begin
                  count_d = reload_q;
                  psc_d   = 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      count   = count_q;
      busy    = (state_q == S_RUN);
      expired = (state_q == S_DONE);
      tc      = tc_q;
      hex_lo  = seg7(count_q[3:0]);
      hex_hi  = seg7(count_q[7:4]);
   end

endmodule

// File: tb/tb_down_timer_8bit.sv
// tb/tb_down_timer_8bit.sv - scoreboard bench for down_timer_8bit at PRESCALE 1, 4 and 256
module tb_down_timer_8bit;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int PS [3] = '{1, 4, 256};

   typedef struct packed {
      logic [7:0] cnt;
      logic       busy;
      logic       expired;
      logic       tc;
   } obs_t;

   typedef struct packed {
      obs_t [2:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       auto_reload = 1'b0;

   logic [7:0] cnt_w     [3];
   logic       busy_w    [3];
   logic       expired_w [3];
   logic       tc_w      [3];
   logic [6:0] hlo_w     [3];
   logic [6:0] hhi_w     [3];

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int m_mode [3];
   int m_cnt  [3];
   int m_rld  [3];
   int m_ph   [3];
   bit m_tc   [3];

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   bit   ar_r;

   always #5 clk = ~clk;

   down_timer_8bit #(.PRESCALE(1)) u_ps1 (
      .clk(clk), .clear(clear), .load(load), .load_val(load_val), .start(start), .stop(stop),
      .auto_reload(auto_reload), .count(cnt_w[0]), .busy(busy_w[0]), .expired(expired_w[0]),
      .tc(tc_w[0]), .hex_lo(hlo_w[0]), .hex_hi(hhi_w[0]));

   down_timer_8bit #(.PRESCALE(4)) u_ps4 (
      .clk(clk), .clear(clear), .load(load), .load_val(load_val), .start(start), .stop(stop),
      .auto_reload(auto_reload), .count(cnt_w[1]), .busy(busy_w[1]), .expired(expired_w[1]),
      .tc(tc_w[1]), .hex_lo(hlo_w[1]), .hex_hi(hhi_w[1]));

   down_timer_8bit #(.PRESCALE(256)) u_ps256 (
      .clk(clk), .clear(clear), .load(load), .load_val(load_val), .start(start), .stop(stop),
      .auto_reload(auto_reload), .count(cnt_w[2]), .busy(busy_w[2]), .expired(expired_w[2]),
      .tc(tc_w[2]), .hex_lo(hlo_w[2]), .hex_hi(hhi_w[2]));

   task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = M_IDLE;
         m_cnt[k]  = 0;
         m_rld[k]  = 0;
         m_ph[k]   = 0;
         m_tc[k]   = 1'b0;
      end
   endtask

   // Timer behaviour expressed as phase counting over whole cycles.
   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         m_tc[k] = 1'b0;
         if (load) begin
            m_cnt[k] = int'(load_val); m_rld[k] = int'(load_val); m_ph[k] = 0; m_mode[k] = M_IDLE;
         end else if (m_mode[k] == M_IDLE) begin
            if (!stop && start && m_cnt[k] != 0) m_mode[k] = M_RUN;
         end else if (m_mode[k] == M_RUN) begin
            if (stop) m_mode[k] = M_IDLE;
            else begin
               m_ph[k] = m_ph[k] + 1;
               if (m_ph[k] == PS[k]) begin
                  m_ph[k] = 0;
                  if (m_cnt[k] > 1) m_cnt[k] = m_cnt[k] - 1;
                  else begin
                     m_tc[k] = 1'b1;
                     if (auto_reload) m_cnt[k] = m_rld[k];
                     else begin m_cnt[k] = 0; m_mode[k] = M_DONE; end
                  end
               end
            end
         end else begin
            if (!stop && start && m_rld[k] != 0) begin
               m_cnt[k] = m_rld[k]; m_ph[k] = 0; m_mode[k] = M_RUN;
            end
         end
      end
   endtask

   task automatic cyc(input bit ld, input logic [7:0] lv, input bit st, input bit sp, input bit ar);
      exp_t e;
      load = ld; load_val = lv; start = st; stop = sp; auto_reload = ar;
      @(posedge clk);
      model_step();
      for (int k = 0; k < 3; k++) begin
         e.d[k].cnt     = 8'(m_cnt[k]);
         e.d[k].busy    = (m_mode[k] == M_RUN);
         e.d[k].expired = (m_mode[k] == M_DONE);
         e.d[k].tc      = m_tc[k];
      end
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ar);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, ar);
   endtask

   task automatic check_reset_state();
      for (int k = 0; k < 3; k++) begin
         chk("rst_count", k, cnt_w[k], 8'h00);
         chk("rst_busy", k, 8'(busy_w[k]), 8'h0);
         chk("rst_expired", k, 8'(expired_w[k]), 8'h0);
         chk("rst_tc", k, 8'(tc_w[k]), 8'h0);
         chk("rst_hex_lo", k, 8'(hlo_w[k]), 8'h40);
         chk("rst_hex_hi", k, 8'(hhi_w[k]), 8'h40);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         for (int k = 0; k < 3; k++) begin
            chk("count", k, cnt_w[k], mon_e.d[k].cnt);
            chk("busy", k, 8'(busy_w[k]), 8'(mon_e.d[k].busy));
            chk("expired", k, 8'(expired_w[k]), 8'(mon_e.d[k].expired));
            chk("tc", k, 8'(tc_w[k]), 8'(mon_e.d[k].tc));
            chk("hex_lo", k, 8'(hlo_w[k]), 8'(seg_tab[mon_e.d[k].cnt[3:0]]));
            chk("hex_hi", k, 8'(hhi_w[k]), 8'(seg_tab[mon_e.d[k].cnt[7:4]]));
         end
      end
   end

   initial begin
      model_reset();
      #13;
      check_reset_state();
      @(negedge clk);
      clear = 1'b1;
      #1;

      // one-shot from 3
      cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(10, 1'b0);

      // auto-reload from 2
      cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      idle(26, 1'b1);

      // pause mid-prescale, resume, then load+stop+start together
      cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(7, 1'b0);
      cyc(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b0);

      // expire, restart from DONE, then zero load
      cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(10, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(10, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      idle(4, 1'b1);

      // display glyphs
      cyc(1'b1, 8'h9F, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hE8, 1'b0, 1'b0, 1'b0);

      // randomized traffic
      ar_r = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         bit         ld, st, sp;
         logic [7:0] lv;
         if ($urandom_range(0, 49) == 0) ar_r = ~ar_r;
         ld = ($urandom_range(0, 39) == 0);
         lv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 24) == 0);
         cyc(ld, lv, st, sp, ar_r);
      end

      // asynchronous clear mid-run from 8'h5A
      cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b0);
      #2;
      clear = 1'b0;
      model_reset();
      #1;
      check_reset_state();
      @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      clear = 1'b1;
      #1;
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);

      @(negedge clk);
      #1;
      chk("sb_drained", 0, 8'(sb.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
